pop_sequencer: RTL and testbench
================================

Name: pop_sequencer

Overview:
Second-generation POP (pump / Ramsey microwave / probe) timing sequencer.
- Phase durations are runtime-programmable through a small config write port; they are not elaboration-time constants.
- Supports N repetitions or continuous looping, with a clean end-of-iteration stop.
- Outputs are registered; sits between the host control interface and the top-level laser/MW/ADC drive pins.

Parameters:
- WIDTH, 16: phase duration / timer width, in clock_2_5M cycles.
- NCYC_W, 8: width of repeat count and iteration counter.
- PUMP_DEF, 1000: reset value of the pump duration.
- PIO2_DEF, 1000: reset value of each pi/2 MW pulse duration.
- FREEP_DEF, 7500: reset value of the free-precession gap.
- PROBE_DEF, 375: reset value of the probe duration.
- SDELAY_DEF, 0: reset value of the sample delay from probe start.
- SLEN_DEF, 125: reset value of the sample window length.
- GAP_DEF, 125: reset value of each laser/MW guard gap.

Ports:
- clock_2_5M, input, 1: 2.5 MHz system clock. Single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- cfg_we, input, 1: config write strobe.
- cfg_addr, input, 3: register select. 0 pump, 1 pio2, 2 freep, 3 probe, 4 sdelay, 5 slen, 6 gap; 7 reserved.
- cfg_data, input, WIDTH: write data.
- cfg_rej, output, 1: one-cycle pulse when a write is rejected.
- start, input, 1: begin a run; sampled only in IDLE.
- stop, input, 1: request stop at the end of the current iteration.
- continuous, input, 1: latched at start; 1 = loop until stop.
- n_cycles, input, NCYC_W: iterations per run, latched at start; 0 is treated as 1.
- pump, output, 1: pump laser gate.
- MW, output, 1: microwave gate.
- probe, output, 1: probe laser gate.
- sample, output, 1: optical sample / ADC gate.
- busy, output, 1: high from the first PUMP cycle through the last GAP3 cycle.
- done, output, 1: one-cycle pulse after a run completes.
- cycle_count, output, NCYC_W: iterations completed in the current/last run.

Behaviour:
- Reset (async): FSM goes to IDLE. All outputs, cycle_count and the stop_pending flag clear to 0. Config registers load their *_DEF values.
- Config writes:
  - Accepted only in IDLE.
  - cfg_we while busy, or to addr 7: no write, and cfg_rej pulses the next cycle.
- FSM states: IDLE, PUMP, GAP1, PI1, FREE, PI2, GAP2, PROBE, GAP3.
  - Each phase holds for exactly its programmed number of cycles, timed by a down-counter loaded with dur-1.
  - A phase of duration 0 is skipped (0 cycles); the FSM evaluates the next phase in the same transition.
- Start latency: start high at rising edge k in IDLE puts the FSM in PUMP at cycle k+1; pump is high in cycles k+1..k+PUMP.
- Output timing: outputs are registered and aligned to the state (no glitches, no combinational decode to pins).
  - pump = PUMP.
  - MW = PI1 or PI2.
  - probe = PROBE.
- Sample window:
  - A separate offset counter starts at 0 in the first PROBE cycle.
  - sample is high for offsets in [SDELAY, SDELAY+SLEN); the sum is computed in WIDTH+1 bits, with no wrap.
  - The window may extend into GAP3 and is truncated at the end of GAP3.
  - SLEN=0 gives no sample.
- Iteration end (last GAP3 cycle):
  - cycle_count increments, saturating at all-ones.
  - If stop_pending, or (!continuous and cycle_count+1 >= n), the FSM goes to IDLE, busy drops and done pulses in that cycle.
  - Otherwise the FSM goes straight to PUMP with no idle cycle.
- stop:
  - Any stop while busy sets stop_pending.
  - The current iteration always completes; gates are never truncated mid-phase.
- start:
  - start while busy is ignored.
  - start and stop in the same IDLE cycle: the run starts and executes exactly one iteration.
  - cycle_count clears on each accepted start.
- All-zero durations: an iteration takes 0 cycles. This is forbidden: a minimum of 1 cycle is enforced in GAP3 (a programmed 0 is treated as 1).

Decomposition:
- Package pop_pkg:
  - state enum;
  - cfg address constants;
  - default duration constants.
- One sub-module, pop_phase_timer:
  - loadable WIDTH-bit down-counter;
  - last-cycle flag;
  - zero-length detect.
  - It is instantiated once for phases and once for the sample offset.

Test Plan:
- Reset, then read defaults: start with n=1. Required: pump high 1000 cycles, MW 1000, gap 7500, MW 1000, probe 375, sample 125 cycles beginning with probe; done 1 cycle after the end.
- Program pump=4, gap=2, pio2=3, freep=5, probe=6, sdelay=1, slen=2; start at edge 0, n=1. Required:
  - pump high cycles 1-4;
  - MW high 7-9 and 15-17;
  - probe high 20-25;
  - sample high 21-22;
  - done at 28; busy high 1-27.
- Same config with n=3. Required: three back-to-back 27-cycle iterations, pump rising at cycles 1, 28 and 55; cycle_count=3; a single done pulse at cycle 82.
- continuous=1, stop asserted at cycle 40. Required: iteration 2 completes, done at 55, no pump at 55, cycle_count=2.
- Write during busy. Required: cfg_rej pulses, and the register is unchanged on the next run.
- Set sdelay=5, slen=10, then assert reset at cycle 10 mid-run. Required:
  - the sample window is truncated at the end of GAP3;
  - the reset drives all outputs low immediately, restores defaults, and leaves the FSM in IDLE.

Source files
------------

// File: rtl/pop_pkg.sv
// rtl/pop_pkg.sv - states, config addresses, defaults and phase-walk helpers for the POP sequencer
package pop_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_PUMP  = 4'd1;
  localparam state_t S_GAP1  = 4'd2;
  localparam state_t S_PI1   = 4'd3;
  localparam state_t S_FREE  = 4'd4;
  localparam state_t S_PI2   = 4'd5;
  localparam state_t S_GAP2  = 4'd6;
  localparam state_t S_PROBE = 4'd7;
  localparam state_t S_GAP3  = 4'd8;

  localparam logic [2:0] CFG_PUMP   = 3'd0;
  localparam logic [2:0] CFG_PIO2   = 3'd1;
  localparam logic [2:0] CFG_FREEP  = 3'd2;
  localparam logic [2:0] CFG_PROBE  = 3'd3;
  localparam logic [2:0] CFG_SDELAY = 3'd4;
  localparam logic [2:0] CFG_SLEN   = 3'd5;
  localparam logic [2:0] CFG_GAP    = 3'd6;
  localparam logic [2:0] CFG_RSVD   = 3'd7;

  localparam int POP_PUMP_DEF   = 1000;
  localparam int POP_PIO2_DEF   = 1000;
  localparam int POP_FREEP_DEF  = 7500;
  localparam int POP_PROBE_DEF  = 375;
  localparam int POP_SDELAY_DEF = 0;
  localparam int POP_SLEN_DEF   = 125;
  localparam int POP_GAP_DEF    = 125;

  function automatic state_t phase_succ(input state_t s);
    state_t r;
    case (s)
      S_PUMP:  r = S_GAP1;
      S_GAP1:  r = S_PI1;
      S_PI1:   r = S_FREE;
      S_FREE:  r = S_PI2;
      S_PI2:   r = S_GAP2;
      S_GAP2:  r = S_PROBE;
      S_PROBE: r = S_GAP3;
      default: r = S_PUMP;
    endcase
    return r;
  endfunction

  // GAP3 is never zero-length, so the walk always settles within eight steps.
  function automatic state_t first_live(input state_t s, input logic [15:0] live);
    state_t c;
    c = s;
    for (int i = 0; i < 8; i++) begin
      if (!live[c]) c = phase_succ(c);
    end
    return c;
  endfunction

endpackage

// File: rtl/pop_phase_timer.sv
// rtl/pop_phase_timer.sv - loadable down-counter with last-cycle and zero-length flags
module pop_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] dur_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = dur_i - W'(1);
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == '0);
  assign zero_o = (dur_i == '0);

endmodule

// File: rtl/pop_sequencer.sv
// rtl/pop_sequencer.sv - programmable pump / Ramsey MW / probe timing sequencer with registered gates
module pop_sequencer
  import pop_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NCYC_W     = 8,
  parameter int PUMP_DEF   = POP_PUMP_DEF,
  parameter int PIO2_DEF   = POP_PIO2_DEF,
  parameter int FREEP_DEF  = POP_FREEP_DEF,
  parameter int PROBE_DEF  = POP_PROBE_DEF,
  parameter int SDELAY_DEF = POP_SDELAY_DEF,
  parameter int SLEN_DEF   = POP_SLEN_DEF,
  parameter int GAP_DEF    = POP_GAP_DEF
) (
  input  logic              clock_2_5M,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  output logic              cfg_rej,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NCYC_W-1:0] n_cycles,
  output logic              pump,
  output logic              MW,
  output logic              probe,
  output logic              sample,
  output logic              busy,
  output logic              done,
  output logic [NCYC_W-1:0] cycle_count
);

  localparam int OW = WIDTH + 1;
  localparam int CW = NCYC_W + 1;

  logic [WIDTH-1:0]  pump_len_q, pio2_len_q, freep_len_q, probe_len_q, sdelay_q, slen_q, gap_len_q;
  state_t            state_q, state_d;
  logic [NCYC_W-1:0] ncyc_q, ncyc_d, count_q, count_d;
  logic              cont_q, cont_d, stop_pend_q, stop_pend_d;
  logic              pump_q, mw_q, probe_q, sample_q, busy_q, done_q, rej_q;
  logic              done_d, sample_d, adv;
  logic [WIDTH-1:0]  dur_tab [16];
  logic [15:0]       live;
  logic              ph_load, ph_last, ph_zero;
  logic [WIDTH-1:0]  ph_dur, ph_cnt;
  logic [OW-1:0]     off_cnt, off_cur, off_next, win_start, win_end;
  logic              off_load, off_en, off_last, off_zero;
  logic              unused_ok;

  always_comb begin
    for (int i = 0; i < 16; i++) dur_tab[i] = '0;
    dur_tab[S_PUMP]  = pump_len_q;
    dur_tab[S_GAP1]  = gap_len_q;
    dur_tab[S_PI1]   = pio2_len_q;
    dur_tab[S_FREE]  = freep_len_q;
    dur_tab[S_PI2]   = pio2_len_q;
    dur_tab[S_GAP2]  = gap_len_q;
    dur_tab[S_PROBE] = probe_len_q;
    dur_tab[S_GAP3]  = (gap_len_q == '0) ? WIDTH'(1) : gap_len_q;
    for (int i = 0; i < 16; i++) live[i] = (dur_tab[i] != '0);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ncyc_d      = ncyc_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    adv         = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        adv         = 1'b1;
        state_d     = first_live(S_PUMP, live);
        count_d     = '0;
        ncyc_d      = (n_cycles == '0) ? NCYC_W'(1) : n_cycles;
        cont_d      = continuous;
        stop_pend_d = stop;
      end
    end else begin
      if (stop) stop_pend_d = 1'b1;
      if (ph_last) begin
        adv = 1'b1;
        if (state_q == S_GAP3) begin
          if (count_q != '1) count_d = count_q + NCYC_W'(1);
          if (stop_pend_q || (!cont_q && ({1'b0, count_q} + CW'(1)) >= {1'b0, ncyc_q})) begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = first_live(S_PUMP, live);
          end
        end else begin
          state_d = first_live(phase_succ(state_q), live);
        end
      end
    end
  end

  // Going idle selects a zero duration, which leaves the phase timer parked.
  assign ph_dur  = dur_tab[state_d];
  assign ph_load = adv && !ph_zero;

  pop_phase_timer #(.W(WIDTH)) u_phase (
    .clk    (clock_2_5M),
    .rst    (reset),
    .load_i (ph_load),
    .dur_i  (ph_dur),
    .en_i   (state_q != S_IDLE),
    .cnt_o  (ph_cnt),
    .last_o (ph_last),
    .zero_o (ph_zero)
  );

  // Offset runs as the complement of a counter loaded with all-ones, so it reads 0 in the first probe-region cycle.
  assign off_load = adv && (state_d == S_PROBE || state_d == S_GAP3)
                    && !(state_q == S_PROBE && state_d == S_GAP3);
  assign off_en   = (state_q == S_PROBE) || (state_q == S_GAP3);

  pop_phase_timer #(.W(OW)) u_offset (
    .clk    (clock_2_5M),
    .rst    (reset),
    .load_i (off_load),
    .dur_i  ('0),
    .en_i   (off_en),
    .cnt_o  (off_cnt),
    .last_o (off_last),
    .zero_o (off_zero)
  );

  assign off_cur   = ~off_cnt;
  assign off_next  = off_load ? '0 : off_cur + OW'(1);
  assign win_start = {1'b0, sdelay_q};
  assign win_end   = {1'b0, sdelay_q} + {1'b0, slen_q};
  assign sample_d  = (state_d == S_PROBE || state_d == S_GAP3)
                     && off_next >= win_start && off_next < win_end;
  assign unused_ok = ^{ph_cnt, off_last, off_zero};

  always_ff @(posedge clock_2_5M or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      ncyc_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      pump_q      <= 1'b0;
      mw_q        <= 1'b0;
      probe_q     <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
      pump_len_q  <= WIDTH'(PUMP_DEF);
      pio2_len_q  <= WIDTH'(PIO2_DEF);
      freep_len_q <= WIDTH'(FREEP_DEF);
      probe_len_q <= WIDTH'(PROBE_DEF);
      sdelay_q    <= WIDTH'(SDELAY_DEF);
      slen_q      <= WIDTH'(SLEN_DEF);
      gap_len_q   <= WIDTH'(GAP_DEF);
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ncyc_q      <= ncyc_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      pump_q      <= (state_d == S_PUMP);
      mw_q        <= (state_d == S_PI1) || (state_d == S_PI2);
      probe_q     <= (state_d == S_PROBE);
      sample_q    <= sample_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
      rej_q       <= cfg_we && (state_q != S_IDLE || cfg_addr == CFG_RSVD);
      if (cfg_we && state_q == S_IDLE) begin
        case (cfg_addr)
          CFG_PUMP:   pump_len_q  <= cfg_data;
          CFG_PIO2:   pio2_len_q  <= cfg_data;
          CFG_FREEP:  freep_len_q <= cfg_data;
          CFG_PROBE:  probe_len_q <= cfg_data;
          CFG_SDELAY: sdelay_q    <= cfg_data;
          CFG_SLEN:   slen_q      <= cfg_data;
          CFG_GAP:    gap_len_q   <= cfg_data;
          default: ;
        endcase
      end
    end
  end

  assign pump        = pump_q;
  assign MW          = mw_q;
  assign probe       = probe_q;
  assign sample      = sample_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_rej     = rej_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_pop_sequencer.sv
// tb/tb_pop_sequencer.sv - directed self-checking bench for pop_sequencer
module tb_pop_sequencer;

  logic        clock_2_5M = 1'b0;
  logic        reset, cfg_we, start, stop, continuous;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [7:0]  n_cycles;
  logic        cfg_rej, pump, MW, probe, sample, busy, done;
  logic [7:0]  cycle_count;

  int checks = 0;
  int errors = 0;
  logic [127:0] v_pump, v_mw, v_probe, v_sample, v_busy, v_done;
  int n_pump, n_mw, n_probe, n_sample, n_busy, n_done;
  int f_pump, f_mw, f_probe, f_sample, f_done, l_mw;

  always #5 clock_2_5M = ~clock_2_5M;

  pop_sequencer dut (
    .clock_2_5M (clock_2_5M),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_rej    (cfg_rej),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .n_cycles   (n_cycles),
    .pump       (pump),
    .MW         (MW),
    .probe      (probe),
    .sample     (sample),
    .busy       (busy),
    .done       (done),
    .cycle_count(cycle_count)
  );

  function automatic logic [127:0] rng(input int a, input int b);
    logic [127:0] r;
    r = '0;
    for (int i = a; i <= b; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Cycle c is the c-th clock period after the edge that samples start.
  task automatic run(input int ncyc, input int stop_at);
    v_pump = '0; v_mw = '0; v_probe = '0; v_sample = '0; v_busy = '0; v_done = '0;
    n_pump = 0; n_mw = 0; n_probe = 0; n_sample = 0; n_busy = 0; n_done = 0;
    f_pump = 0; f_mw = 0; f_probe = 0; f_sample = 0; f_done = 0; l_mw = 0;
    stop  = (stop_at == 0);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clock_2_5M);
      #1;
      start = 1'b0;
      stop  = (c == stop_at);
      if (c < 128) begin
        v_pump[c] = pump; v_mw[c] = MW; v_probe[c] = probe;
        v_sample[c] = sample; v_busy[c] = busy; v_done[c] = done;
      end
      if (pump)   begin n_pump++;   if (f_pump == 0)   f_pump = c;   end
      if (MW)     begin n_mw++;     if (f_mw == 0)     f_mw = c; l_mw = c; end
      if (probe)  begin n_probe++;  if (f_probe == 0)  f_probe = c;  end
      if (sample) begin n_sample++; if (f_sample == 0) f_sample = c; end
      if (busy)   n_busy++;
      if (done)   begin n_done++;   if (f_done == 0)   f_done = c;   end
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d, input logic exp_rej);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clock_2_5M);
    #1;
    cfg_we = 1'b0;
    checks++;
    if (cfg_rej !== exp_rej) begin
      errors++; $display("FAIL cfg_rej_addr%0d got %b exp %b", a, cfg_rej, exp_rej);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    n_cycles = 8'd1; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clock_2_5M);
    #1;
    checks++;
    if ({pump, MW, probe, sample, busy, done, cfg_rej} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000000", {pump, MW, probe, sample, busy, done, cfg_rej});
    end
    checks++;
    if (cycle_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cycle_count); end
    reset = 1'b0;
    repeat (2) @(posedge clock_2_5M);
    #1;
    checks++;
    if ({pump, MW, probe, busy, done} !== 5'b0) begin
      errors++; $display("FAIL idle_after_reset got %b exp 00000", {pump, MW, probe, busy, done});
    end
  endtask

  task automatic test_defaults(input string tag);
    run(11260, -1);
    checks++; if (n_pump !== 1000 || f_pump !== 1) begin errors++; $display("FAIL %s_pump got n=%0d first=%0d exp n=1000 first=1", tag, n_pump, f_pump); end
    checks++; if (n_mw !== 2000) begin errors++; $display("FAIL %s_mw_len got %0d exp 2000", tag, n_mw); end
    checks++; if (f_mw !== 1126 || l_mw !== 10625) begin errors++; $display("FAIL %s_mw_span got %0d..%0d exp 1126..10625", tag, f_mw, l_mw); end
    checks++; if (n_probe !== 375 || f_probe !== 10751) begin errors++; $display("FAIL %s_probe got n=%0d first=%0d exp n=375 first=10751", tag, n_probe, f_probe); end
    checks++; if (n_sample !== 125 || f_sample !== 10751) begin errors++; $display("FAIL %s_sample got n=%0d first=%0d exp n=125 first=10751", tag, n_sample, f_sample); end
    checks++; if (n_done !== 1 || f_done !== 11251) begin errors++; $display("FAIL %s_done got n=%0d at=%0d exp n=1 at=11251", tag, n_done, f_done); end
    checks++; if (n_busy !== 11250) begin errors++; $display("FAIL %s_busy got %0d exp 11250", tag, n_busy); end
  endtask

  task automatic test_single();
    cfg_write(3'd0, 16'd4, 1'b0);
    cfg_write(3'd6, 16'd2, 1'b0);
    cfg_write(3'd1, 16'd3, 1'b0);
    cfg_write(3'd2, 16'd5, 1'b0);
    cfg_write(3'd3, 16'd6, 1'b0);
    cfg_write(3'd4, 16'd1, 1'b0);
    cfg_write(3'd5, 16'd2, 1'b0);
    n_cycles = 8'd1;
    run(40, -1);
    checks++; if (v_pump !== rng(1, 4)) begin errors++; $display("FAIL single_pump got %h exp %h", v_pump, rng(1, 4)); end
    checks++; if (v_mw !== (rng(7, 9) | rng(15, 17))) begin errors++; $display("FAIL single_mw got %h exp %h", v_mw, rng(7, 9) | rng(15, 17)); end
    checks++; if (v_probe !== rng(20, 25)) begin errors++; $display("FAIL single_probe got %h exp %h", v_probe, rng(20, 25)); end
    checks++; if (v_sample !== rng(21, 22)) begin errors++; $display("FAIL single_sample got %h exp %h", v_sample, rng(21, 22)); end
    checks++; if (v_busy !== rng(1, 27)) begin errors++; $display("FAIL single_busy got %h exp %h", v_busy, rng(1, 27)); end
    checks++; if (v_done !== rng(28, 28)) begin errors++; $display("FAIL single_done got %h exp %h", v_done, rng(28, 28)); end
    checks++; if (cycle_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", cycle_count); end
  endtask

  task automatic test_back_to_back();
    n_cycles = 8'd3;
    run(90, -1);
    checks++; if (v_pump !== (rng(1, 4) | rng(28, 31) | rng(55, 58))) begin errors++; $display("FAIL b2b_pump got %h", v_pump); end
    checks++; if (v_probe !== (rng(20, 25) | rng(47, 52) | rng(74, 79))) begin errors++; $display("FAIL b2b_probe got %h", v_probe); end
    checks++; if (v_busy !== rng(1, 81)) begin errors++; $display("FAIL b2b_busy got %h exp %h", v_busy, rng(1, 81)); end
    checks++; if (v_done !== rng(82, 82)) begin errors++; $display("FAIL b2b_done got %h exp %h", v_done, rng(82, 82)); end
    checks++; if (cycle_count !== 8'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", cycle_count); end
  endtask

  task automatic test_stop();
    continuous = 1'b1; n_cycles = 8'd0;
    run(70, 40);
    checks++; if (v_pump !== (rng(1, 4) | rng(28, 31))) begin errors++; $display("FAIL stop_pump got %h exp %h", v_pump, rng(1, 4) | rng(28, 31)); end
    checks++; if (v_busy !== rng(1, 54)) begin errors++; $display("FAIL stop_busy got %h exp %h", v_busy, rng(1, 54)); end
    checks++; if (v_done !== rng(55, 55)) begin errors++; $display("FAIL stop_done got %h exp %h", v_done, rng(55, 55)); end
    checks++; if (cycle_count !== 8'd2) begin errors++; $display("FAIL stop_count got %0d exp 2", cycle_count); end
    continuous = 1'b0; n_cycles = 8'd1;
  endtask

  task automatic test_start_stop_same();
    continuous = 1'b1; n_cycles = 8'd5;
    run(40, 0);
    checks++; if (v_busy !== rng(1, 27)) begin errors++; $display("FAIL startstop_busy got %h exp %h", v_busy, rng(1, 27)); end
    checks++; if (v_done !== rng(28, 28)) begin errors++; $display("FAIL startstop_done got %h exp %h", v_done, rng(28, 28)); end
    checks++; if (cycle_count !== 8'd1) begin errors++; $display("FAIL startstop_count got %0d exp 1", cycle_count); end
    continuous = 1'b0; n_cycles = 8'd1;
  endtask

  task automatic test_cfg_reject();
    int waited;
    start = 1'b1;
    @(posedge clock_2_5M);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock_2_5M);
    #1;
    cfg_write(3'd0, 16'd9, 1'b1);
    @(posedge clock_2_5M);
    #1;
    checks++; if (cfg_rej !== 1'b0) begin errors++; $display("FAIL rej_pulse_width got %b exp 0", cfg_rej); end
    waited = 0;
    while (busy && waited < 100) begin
      @(posedge clock_2_5M);
      #1;
      waited++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_run_end got busy=%b exp 0", busy); end
    cfg_write(3'd7, 16'd5, 1'b1);
    run(40, -1);
    checks++; if (v_pump !== rng(1, 4)) begin errors++; $display("FAIL rej_pump_unchanged got %h exp %h", v_pump, rng(1, 4)); end
  endtask

  task automatic test_zero_skip();
    cfg_write(3'd6, 16'd0, 1'b0);
    cfg_write(3'd1, 16'd0, 1'b0);
    run(25, -1);
    checks++; if (v_mw !== '0) begin errors++; $display("FAIL zero_mw got %h exp 0", v_mw); end
    checks++; if (v_probe !== rng(10, 15)) begin errors++; $display("FAIL zero_probe got %h exp %h", v_probe, rng(10, 15)); end
    checks++; if (v_sample !== rng(11, 12)) begin errors++; $display("FAIL zero_sample got %h exp %h", v_sample, rng(11, 12)); end
    checks++; if (v_busy !== rng(1, 16)) begin errors++; $display("FAIL zero_busy got %h exp %h", v_busy, rng(1, 16)); end
    checks++; if (v_done !== rng(17, 17)) begin errors++; $display("FAIL zero_done got %h exp %h", v_done, rng(17, 17)); end
    cfg_write(3'd6, 16'd2, 1'b0);
    cfg_write(3'd1, 16'd3, 1'b0);
  endtask

  task automatic test_sample_trunc_and_reset();
    cfg_write(3'd4, 16'd5, 1'b0);
    cfg_write(3'd5, 16'd10, 1'b0);
    run(40, -1);
    checks++; if (v_sample !== rng(25, 27)) begin errors++; $display("FAIL trunc_sample got %h exp %h", v_sample, rng(25, 27)); end
    start = 1'b1;
    @(posedge clock_2_5M);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock_2_5M);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b exp 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pump, MW, probe, sample, busy, done, cfg_rej, cycle_count} !== 15'b0) begin
      errors++; $display("FAIL async_reset got %b exp 0", {pump, MW, probe, sample, busy, done, cfg_rej, cycle_count});
    end
    @(posedge clock_2_5M);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock_2_5M);
    #1;
    checks++; if ({busy, pump, MW, probe} !== 4'b0) begin errors++; $display("FAIL post_reset_idle got %b exp 0000", {busy, pump, MW, probe}); end
  endtask

  initial begin
    test_reset();
    test_defaults("defaults");
    test_single();
    test_back_to_back();
    test_stop();
    test_start_stop_same();
    test_cfg_reject();
    test_zero_skip();
    test_sample_trunc_and_reset();
    test_defaults("restored");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
